// File: rtl/decode_hazard_stage_pkg.sv
// decode_pkg: shared opcode/funct encodings, control-bundle field indices and
// the combinational decode helpers used by the decode stage and its bench.
//   decode_ctl  : opcode/funct -> control bundle (ctl_t)
//   decode_dest : opcode -> which instruction field names the destination
//   rt_is_src   : opcode -> whether rt is read as a source operand
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JUMP  = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LDB   = 6'h20;
  localparam logic [5:0] OP_LDW   = 6'h23;
  localparam logic [5:0] OP_STB   = 6'h28;
  localparam logic [5:0] OP_STW   = 6'h2B;

  localparam logic [5:0] FN_MUL   = 6'h18;

  // Control bundle bit positions
  localparam int unsigned CTL_REGWRITE = 0;
  localparam int unsigned CTL_MEMTOREG = 1;
  localparam int unsigned CTL_MEMREAD  = 2;
  localparam int unsigned CTL_MEMWRITE = 3;
  localparam int unsigned CTL_BYTEWORD = 4;
  localparam int unsigned CTL_ALUSRC   = 5;
  localparam int unsigned CTL_IS_MULT  = 6;
  localparam int unsigned CTL_W        = 7;

  typedef logic [CTL_W-1:0] ctl_t;

  typedef enum logic [1:0] {
    DST_RD,
    DST_RT,
    DST_NONE
  } dest_sel_e;

  function automatic ctl_t decode_ctl(input logic [5:0] op, input logic [5:0] fn);
    ctl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c[CTL_REGWRITE] = 1'b1;
        c[CTL_IS_MULT]  = (fn == FN_MUL);
      end
      OP_LDW: begin
        c[CTL_REGWRITE] = 1'b1;
        c[CTL_MEMTOREG] = 1'b1;
        c[CTL_MEMREAD]  = 1'b1;
        c[CTL_ALUSRC]   = 1'b1;
      end
      OP_LDB: begin
        c[CTL_REGWRITE] = 1'b1;
        c[CTL_MEMTOREG] = 1'b1;
        c[CTL_MEMREAD]  = 1'b1;
        c[CTL_BYTEWORD] = 1'b1;
        c[CTL_ALUSRC]   = 1'b1;
      end
      OP_STW: begin
        c[CTL_MEMWRITE] = 1'b1;
        c[CTL_ALUSRC]   = 1'b1;
      end
      OP_STB: begin
        c[CTL_MEMWRITE] = 1'b1;
        c[CTL_BYTEWORD] = 1'b1;
        c[CTL_ALUSRC]   = 1'b1;
      end
      default: c = '0;  // JUMP, BEQ and unknown opcodes carry no controls
    endcase
    return c;
  endfunction

  function automatic dest_sel_e decode_dest(input logic [5:0] op);
    dest_sel_e d;
    case (op)
      OP_LDW, OP_LDB:                  d = DST_RT;
      OP_STW, OP_STB, OP_JUMP, OP_BEQ: d = DST_NONE;
      default:                         d = DST_RD;
    endcase
    return d;
  endfunction

  function automatic logic rt_is_src(input logic [5:0] op);
    return !((op == OP_LDW) || (op == OP_LDB));
  endfunction

endpackage

// File: rtl/decode_hazard_stage_if.sv
// decode_hazard_stage_if: fetch-side valid/ready handshake plus the ID/EX
// output bundle of the decode stage.
//   slave  : the decode stage (consumes in_*, drives in_ready and out_*)
//   master : fetch/execute environment (drives in_*, observes the rest)
interface decode_hazard_stage_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned REG_W  = 32,
  parameter int unsigned RA_W   = 5
);

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_pc;
  logic [31:0]       in_instr;

  logic              out_valid;
  logic [ADDR_W-1:0] out_pc;
  logic [5:0]        out_opcode;
  logic [5:0]        out_funct;
  logic [RA_W-1:0]   out_rs_addr;
  logic [RA_W-1:0]   out_rt_addr;
  logic [RA_W-1:0]   out_dest;
  logic [REG_W-1:0]  out_rs_data;
  logic [REG_W-1:0]  out_rt_data;
  logic [ADDR_W-1:0] out_imm;
  logic              out_regwrite;
  logic              out_memtoreg;
  logic              out_memread;
  logic              out_memwrite;
  logic              out_byteword;
  logic              out_alusrc;
  logic              out_is_mult;

  modport slave (
    input  in_valid, in_pc, in_instr,
    output in_ready,
    output out_valid, out_pc, out_opcode, out_funct,
    output out_rs_addr, out_rt_addr, out_dest, out_rs_data, out_rt_data, out_imm,
    output out_regwrite, out_memtoreg, out_memread, out_memwrite,
    output out_byteword, out_alusrc, out_is_mult
  );

  modport master (
    output in_valid, in_pc, in_instr,
    input  in_ready,
    input  out_valid, out_pc, out_opcode, out_funct,
    input  out_rs_addr, out_rt_addr, out_dest, out_rs_data, out_rt_data, out_imm,
    input  out_regwrite, out_memtoreg, out_memread, out_memwrite,
    input  out_byteword, out_alusrc, out_is_mult
  );

endinterface

// File: rtl/decode_hazard_stage_scoreboard.sv
// mult_scoreboard: tracks multiplies that have left ID/EX but whose results
// are not yet forwardable. MUL_LAT-deep shift register of {valid, dest}.
//   insert_i/insert_dest_i : new in-flight multiply entering stage 0
//   shift_en_i             : advance all entries (oldest retires)
//   match_a_i/match_b_i    : source registers to look up
//   hit_a_o/hit_b_o        : a valid entry holds the matching destination
module mult_scoreboard #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned RA_W    = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            insert_i,
  input  logic [RA_W-1:0] insert_dest_i,
  input  logic            shift_en_i,
  input  logic [RA_W-1:0] match_a_i,
  input  logic [RA_W-1:0] match_b_i,
  output logic            hit_a_o,
  output logic            hit_b_o
);

  logic [MUL_LAT-1:0] vld_q;
  logic [RA_W-1:0]    dst_q [MUL_LAT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < MUL_LAT; i++) begin
        dst_q[i] <= '0;
      end
    end else if (shift_en_i) begin
      vld_q[0] <= insert_i;
      dst_q[0] <= insert_dest_i;
      for (int unsigned i = 1; i < MUL_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        dst_q[i] <= dst_q[i-1];
      end
    end
  end

  always_comb begin
    hit_a_o = 1'b0;
    hit_b_o = 1'b0;
    for (int unsigned i = 0; i < MUL_LAT; i++) begin
      if (vld_q[i] && (dst_q[i] == match_a_i)) hit_a_o = 1'b1;
      if (vld_q[i] && (dst_q[i] == match_b_i)) hit_b_o = 1'b1;
    end
  end

endmodule

// File: rtl/decode_hazard_stage.sv
// decode_hazard_stage: instruction decode with ID/EX boundary register,
// load-use / multiply RAW interlock, bubble insertion and branch flush.
//   clk, reset            : clock, asynchronous active-high reset
//   bus (slave)           : fetch handshake in, ID/EX bundle out
//   flush                 : taken branch, kill ID/EX contents
//   ex_stall              : execute busy, freeze ID/EX and scoreboard
//   rs_addr/rt_addr       : register-file read addresses (combinational)
//   rs_data/rt_data       : register-file read data
//   jump_taken/jump_addr  : fetch redirect for an accepted jump
//   hazard_stall          : RAW interlock active this cycle
module decode_hazard_stage
  import decode_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned REG_W   = 32,
  parameter int unsigned RA_W    = 5,
  parameter int unsigned MUL_LAT = 5
) (
  input  logic               clk,
  input  logic               reset,
  decode_hazard_stage_if.slave bus,
  input  logic               flush,
  input  logic               ex_stall,
  output logic [RA_W-1:0]    rs_addr,
  output logic [RA_W-1:0]    rt_addr,
  input  logic [REG_W-1:0]   rs_data,
  input  logic [REG_W-1:0]   rt_data,
  output logic               jump_taken,
  output logic [ADDR_W-1:0]  jump_addr,
  output logic               hazard_stall
);

  localparam int unsigned IMM_EXT = ADDR_W - 16;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] pc;
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [RA_W-1:0]   rs_addr;
    logic [RA_W-1:0]   rt_addr;
    logic [RA_W-1:0]   dest;
    logic [REG_W-1:0]  rs_data;
    logic [REG_W-1:0]  rt_data;
    logic [ADDR_W-1:0] imm;
    ctl_t              ctl;
  } idex_t;

  idex_t idex_q, idex_d, idex_in;

  logic [31:0]     instr;
  logic [5:0]      op, fn;
  logic [RA_W-1:0] rs, rt, rd, dest_in;
  logic            rs_used, rt_used;
  logic            idex_pending;
  logic            rs_haz, rt_haz;
  logic            in_ready;
  logic            transfer;
  logic            sb_insert, sb_shift;
  logic            sb_hit_rs, sb_hit_rt;

  assign instr = bus.in_instr;
  assign op    = instr[31:26];
  assign fn    = instr[5:0];
  assign rs    = RA_W'(instr[25:21]);
  assign rt    = RA_W'(instr[20:16]);
  assign rd    = RA_W'(instr[15:11]);

  assign rs_addr = rs;
  assign rt_addr = rt;

  always_comb begin
    dest_in = rd;
    case (decode_dest(op))
      DST_RT:   dest_in = rt;
      DST_NONE: dest_in = '0;
      default:  dest_in = rd;
    endcase
  end

  // Register 0 is hard-wired, so it can never be a RAW producer.
  assign rs_used = (rs != '0);
  assign rt_used = rt_is_src(op) && (rt != '0);

  // Loads and multiplies in ID/EX cannot forward to the instruction behind them.
  assign idex_pending = idex_q.valid &&
                        (idex_q.ctl[CTL_MEMREAD] || idex_q.ctl[CTL_IS_MULT]);

  assign rs_haz = rs_used && ((idex_pending && (idex_q.dest == rs)) || sb_hit_rs);
  assign rt_haz = rt_used && ((idex_pending && (idex_q.dest == rt)) || sb_hit_rt);

  assign hazard_stall = bus.in_valid && (rs_haz || rt_haz);
  assign in_ready     = !hazard_stall && !ex_stall;
  assign bus.in_ready = in_ready;
  assign transfer     = bus.in_valid && in_ready;

  assign jump_taken = transfer && (op == OP_JUMP) && !flush;

  // Upper PC bits kept, low 28 bits replaced by the word-aligned target.
  always_comb begin
    jump_addr       = bus.in_pc;
    jump_addr[27:0] = {instr[25:0], 2'b00};
  end

  // A flushed multiply never reaches execute, so it must not be tracked.
  assign sb_insert = idex_q.valid && idex_q.ctl[CTL_IS_MULT] && !ex_stall && !flush;
  assign sb_shift  = !ex_stall;

  mult_scoreboard #(
    .MUL_LAT (MUL_LAT),
    .RA_W    (RA_W)
  ) u_mult_scoreboard (
    .clk           (clk),
    .reset         (reset),
    .insert_i      (sb_insert),
    .insert_dest_i (idex_q.dest),
    .shift_en_i    (sb_shift),
    .match_a_i     (rs),
    .match_b_i     (rt),
    .hit_a_o       (sb_hit_rs),
    .hit_b_o       (sb_hit_rt)
  );

  always_comb begin
    idex_in         = '0;
    idex_in.valid   = 1'b1;
    idex_in.pc      = bus.in_pc;
    idex_in.opcode  = op;
    idex_in.funct   = fn;
    idex_in.rs_addr = rs;
    idex_in.rt_addr = rt;
    idex_in.dest    = dest_in;
    idex_in.rs_data = rs_data;
    idex_in.rt_data = rt_data;
    idex_in.imm     = {{IMM_EXT{instr[15]}}, instr[15:0]};
    idex_in.ctl     = decode_ctl(op, fn);
  end

  // Priority: flush > ex_stall hold > hazard bubble > capture > drain.
  // With ex_stall low and no hazard, in_ready is high, so in_valid alone
  // decides capture.
  always_comb begin
    idex_d = idex_q;
    if (flush) begin
      idex_d.valid = 1'b0;
      idex_d.ctl   = '0;
    end else if (ex_stall) begin
      idex_d = idex_q;
    end else if (hazard_stall) begin
      idex_d.valid = 1'b0;
      idex_d.ctl   = '0;
    end else if (bus.in_valid) begin
      idex_d = idex_in;
    end else begin
      idex_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign bus.out_valid    = idex_q.valid;
  assign bus.out_pc       = idex_q.pc;
  assign bus.out_opcode   = idex_q.opcode;
  assign bus.out_funct    = idex_q.funct;
  assign bus.out_rs_addr  = idex_q.rs_addr;
  assign bus.out_rt_addr  = idex_q.rt_addr;
  assign bus.out_dest     = idex_q.dest;
  assign bus.out_rs_data  = idex_q.rs_data;
  assign bus.out_rt_data  = idex_q.rt_data;
  assign bus.out_imm      = idex_q.imm;
  assign bus.out_regwrite = idex_q.ctl[CTL_REGWRITE];
  assign bus.out_memtoreg = idex_q.ctl[CTL_MEMTOREG];
  assign bus.out_memread  = idex_q.ctl[CTL_MEMREAD];
  assign bus.out_memwrite = idex_q.ctl[CTL_MEMWRITE];
  assign bus.out_byteword = idex_q.ctl[CTL_BYTEWORD];
  assign bus.out_alusrc   = idex_q.ctl[CTL_ALUSRC];
  assign bus.out_is_mult  = idex_q.ctl[CTL_IS_MULT];

endmodule

// File: doc/decode_hazard_stage.md
# decode_hazard_stage

Parametrised instruction-decode stage with an ID/EX boundary register, a valid/ready handshake toward fetch, load-use and multiply RAW hazard detection, bubble insertion and branch flush. It sits between fetch and execute, drives the external register-file read addresses, and tracks in-flight multiplies with a latency-parametrised scoreboard. It replaces the fixed-width decode stage, which has no interlock.

## Interface
- ADDR_W, 32, PC/immediate width (≥ 28)
- REG_W, 32, register data width
- RA_W, 5, register address width
- MUL_LAT, 5, cycles from mult leaving ID/EX until its result is forwardable (1..8)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_pc  in  ADDR_W  PC of instruction
- in_instr  in  32  instruction word
- flush  in  1  branch resolved taken; kill ID/EX contents
- ex_stall  in  1  execute cannot accept; freeze ID/EX
- rs_addr, rt_addr  out  RA_W  register-file read addresses (combinational: instr[25:21], instr[20:16])
- rs_data, rt_data  in  REG_W  register-file read data
- out_valid  out  1  ID/EX holds a live instruction
- out_pc  out  ADDR_W; out_opcode, out_funct  out  6
- out_rs_addr, out_rt_addr, out_dest  out  RA_W
- out_rs_data, out_rt_data  out  REG_W
- out_imm  out  ADDR_W  sign-extended instr[15:0]
- out_regwrite, out_memtoreg, out_memread, out_memwrite, out_byteword, out_alusrc, out_is_mult  out  1
- jump_taken  out  1; jump_addr  out  ADDR_W  (combinational)
- hazard_stall  out  1  RAW interlock active this cycle

## Operation
- Decode: dest = rt for LDW/LDB, 0 for STW/STB/JUMP/BEQ, else rd. rt is a source except for loads; register 0 never creates a hazard.
- out_is_mult = (opcode == OP_RTYPE && funct == FN_MUL).
- Hazard when in_valid and a used source (≠0) matches either:
  - out_dest of a valid ID/EX entry with out_memread or out_is_mult set; or
  - any valid scoreboard entry.
- Scoreboard: MUL_LAT-deep shift register of {valid, dest}. Entry inserted when out_valid & out_is_mult & !ex_stall & !flush. Shifts every cycle ex_stall is low; the oldest entry retires.
- in_ready = !hazard_stall & !ex_stall. Transfer occurs on in_valid & in_ready.
- ID/EX update priority: reset > flush (out_valid←0, control bits←0) > ex_stall (hold) > hazard (bubble: out_valid←0, all write/mem controls←0) > transfer (capture) > no input (out_valid←0).
- jump_taken = in_valid & in_ready & opcode == OP_JUMP & !flush; jump_addr = {in_pc[ADDR_W-1:28], instr[25:0], 2'b00}. A jump enters ID/EX as a valid NOP with all controls 0.
- flush does not clear the scoreboard; mults already issued complete.

## Timing
- Reset (async assert, sync release): out_valid, all control outputs, out_dest, out_pc, out_imm and data/addr registers = 0; scoreboard empty.
- Latency: 1 cycle in_instr → ID/EX outputs.
- Load-use: exactly 1 bubble. Mult-use: consumer stalls until the producer has retired from the scoreboard (MUL_LAT+1 cycles after capture when ex_stall is low).
- Simultaneous flush and ex_stall: flush wins. flush with in_valid: the instruction is dropped; in_ready stays as computed and fetch is redirected.
- hazard_stall and in_ready are combinational from registered state and in_instr; there is no path from out_* back to in_ready except through registers.

## Structure
- Shared package decode_pkg: OP_RTYPE, OP_LDW, OP_LDB, OP_STW, OP_STB, OP_JUMP, OP_BEQ, FN_MUL, plus control-bundle field indices.
- One sub-module, mult_scoreboard (MUL_LAT, RA_W): insert/dest, shift enable, and two RA_W match ports returning hit.
- The control decode is an internal combinational function; there is no separate control register.

## Test plan
- Reset mid-stream: assert reset while out_valid=1 and the scoreboard holds 2 entries → all outputs 0 immediately, scoreboard empty, first instruction after release captured 1 cycle later.
- Load-use: LDW r3←[r1] then ADD r4=r3+r2 → one bubble cycle (out_valid=0, hazard_stall=1, in_ready=0), ADD captured the next cycle; ADD with r0 as source → no stall.
- Mult-use, MUL_LAT=5: MUL r5 then ADD using r5 → ADD held exactly 6 cycles; ex_stall raised for 2 cycles mid-wait → 8 cycles.
- Flush: flush with a valid MUL in ID/EX and ex_stall=1 → out_valid=0 next edge; no scoreboard insertion; dependent ADD not stalled.
- Jump: in_pc=0x3000_0010, instr[25:0]=0x000_0040 → jump_taken=1, jump_addr=0x3000_0100; with hazard active → jump_taken=0.
- Immediate/dest: LDW with imm 0x8000 → out_imm=0xFFFF_8000, out_dest=rt; STW → out_dest=0, out_regwrite=0.
